// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b PCS transmit encoder.
// XGMII characters, 7-bit control codes, block types, sync headers and FSM states.
package pcs_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] BT_CTRL   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_C,
        ST_D,
        ST_E
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_D,
        CLS_C,
        CLS_S,
        CLS_T,
        CLS_E
    } blk_class_e;

    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    function automatic logic [65:0] make_error_block();
        logic [63:0] p;
        p       = '0;
        p[7:0]  = BT_CTRL;
        for (int unsigned i = 0; i < 8; i++) begin
            p[8 + 7*i +: 7] = CODE_ERROR;
        end
        return {p, SYNC_CTRL};
    endfunction

    localparam logic [65:0] ERROR_BLOCK = make_error_block();

endpackage

// File: rtl/pcs_block_encode.sv
// Combinational 8-lane classifier and 64b/66b block encoder.
// Unrecognised lane patterns produce the error block with class E.
module pcs_block_encode
    import pcs_pkg::*;
(
    input  logic [63:0] blk_data,
    input  logic [7:0]  blk_ctl,
    output logic [2:0]  blk_class,
    output logic [65:0] blk_out
);

    localparam logic [7:0] ALL_LANES = 8'hFF;

    logic [7:0]  idle_vec;
    logic [7:0]  err_vec;
    logic        c_ok;
    logic        s0_ok;
    logic        s4_ok;
    logic        t_ok;
    logic [7:0]  hi_mask;
    logic [63:0] c_payload;
    logic [63:0] t_payload;

    always_comb begin
        idle_vec  = '0;
        err_vec   = '0;
        c_payload = '0;
        c_payload[7:0] = BT_CTRL;
        for (int unsigned i = 0; i < 8; i++) begin
            idle_vec[i] = (blk_data[8*i +: 8] == XGMII_IDLE);
            err_vec[i]  = (blk_data[8*i +: 8] == XGMII_ERROR);
            if (err_vec[i]) begin
                c_payload[8 + 7*i +: 7] = CODE_ERROR;
            end
        end
        c_ok  = (blk_ctl == ALL_LANES) && ((idle_vec | err_vec) == ALL_LANES);
        s0_ok = (blk_ctl == 8'h01) && (blk_data[7:0] == XGMII_START);
        s4_ok = (blk_ctl == 8'h1F) && (idle_vec[3:0] == 4'hF) &&
                (blk_data[39:32] == XGMII_START);
    end

    // Terminate in lane k: ctl set exactly on lanes >= k, /T/ at k, /I/ above k.
    // Idle codes are 0x00, so everything after the data bytes stays zero.
    always_comb begin
        t_ok      = 1'b0;
        t_payload = '0;
        hi_mask   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            hi_mask = ALL_LANES << k;
            if ((blk_ctl == hi_mask) && (blk_data[8*k +: 8] == XGMII_TERM) &&
                ((idle_vec | ~(hi_mask << 1)) == ALL_LANES)) begin
                t_ok           = 1'b1;
                t_payload[7:0] = term_type(k[2:0]);
                for (int unsigned j = 0; j < 7; j++) begin
                    if (j < k) begin
                        t_payload[8 + 8*j +: 8] = blk_data[8*j +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        blk_class = CLS_E;
        blk_out   = ERROR_BLOCK;
        if (blk_ctl == '0) begin
            blk_class = CLS_D;
            blk_out   = {blk_data, SYNC_DATA};
        end else if (c_ok) begin
            blk_class = CLS_C;
            blk_out   = {c_payload, SYNC_CTRL};
        end else if (s0_ok) begin
            blk_class = CLS_S;
            blk_out   = {blk_data[63:8], BT_START0, SYNC_CTRL};
        end else if (s4_ok) begin
            blk_class = CLS_S;
            blk_out   = {blk_data[63:40], 4'h0, {4{CODE_IDLE}}, BT_START4, SYNC_CTRL};
        end else if (t_ok) begin
            blk_class = CLS_T;
            blk_out   = {t_payload, SYNC_CTRL};
        end
    end

endmodule

// File: rtl/pcs_tx_encoder.sv
// 64b/66b PCS transmit encoder: pairs 32-bit XGMII beats into 8 lanes,
// enforces frame sequencing, and presents one registered 66-bit block with back-pressure.
module pcs_tx_encoder
    import pcs_pkg::*;
#(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
    input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
    output logic                        out_xgmii_pcs_ready,
    output logic [65:0]                 out_block,
    output logic                        out_block_valid,
    input  logic                        in_block_ready,
    output logic                        enc_error,
    output logic [31:0]                 stat_error_blocks
);

    logic                        phase_q, phase_d;
    logic [XGMII_DATA_WIDTH-1:0] low_data_q, low_data_d;
    logic [XGMII_DATA_BYTES-1:0] low_ctl_q, low_ctl_d;
    logic [65:0]                 block_q, block_d;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;
    logic [31:0]                 stat_q, stat_d;
    seq_state_e                  state_q, state_d;

    logic        accept;
    logic        load;
    logic        legal;
    seq_state_e  seq_next;
    logic [2:0]  cls_raw;
    blk_class_e  cls_e;
    logic [65:0] enc_block;

    assign out_xgmii_pcs_ready = !valid_q || in_block_ready;
    assign accept              = out_xgmii_pcs_ready;
    assign load                = accept && phase_q;

    pcs_block_encode u_encode (
        .blk_data  ({in_xgmii_data, low_data_q}),
        .blk_ctl   ({in_xgmii_ctl, low_ctl_q}),
        .blk_class (cls_raw),
        .blk_out   (enc_block)
    );

    assign cls_e = blk_class_e'(cls_raw);

    // Legal-but-out-of-sequence classes are demoted to error blocks.
    always_comb begin
        unique case (state_q)
            ST_INIT, ST_C: legal = (cls_e == CLS_C) || (cls_e == CLS_S);
            ST_D:          legal = (cls_e == CLS_D) || (cls_e == CLS_T);
            ST_E:          legal = (cls_e != CLS_E);
            default:       legal = 1'b0;
        endcase
        seq_next = ST_E;
        if (legal) begin
            unique case (cls_e)
                CLS_C, CLS_T: seq_next = ST_C;
                CLS_S, CLS_D: seq_next = ST_D;
                default:      seq_next = ST_E;
            endcase
        end
    end

    always_comb begin
        phase_d    = phase_q;
        low_data_d = low_data_q;
        low_ctl_d  = low_ctl_q;
        block_d    = block_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        stat_d     = stat_q;
        state_d    = state_q;
        if (accept) begin
            phase_d = !phase_q;
            if (!phase_q) begin
                low_data_d = in_xgmii_data;
                low_ctl_d  = in_xgmii_ctl;
            end
        end
        if (load) begin
            block_d = legal ? enc_block : ERROR_BLOCK;
            valid_d = 1'b1;
            err_d   = !legal;
            state_d = seq_next;
            if (!legal && (stat_q != '1)) begin
                stat_d = stat_q + 32'd1;
            end
        end else if (valid_q && in_block_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            phase_q    <= 1'b0;
            low_data_q <= '0;
            low_ctl_q  <= '0;
            block_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            stat_q     <= '0;
            state_q    <= ST_INIT;
        end else begin
            phase_q    <= phase_d;
            low_data_q <= low_data_d;
            low_ctl_q  <= low_ctl_d;
            block_q    <= block_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            stat_q     <= stat_d;
            state_q    <= state_d;
        end
    end

    assign out_block         = block_q;
    assign out_block_valid   = valid_q;
    assign enc_error         = err_q;
    assign stat_error_blocks = stat_q;

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Scoreboard bench for pcs_tx_encoder: expected blocks are queued as beat pairs
// are accepted and compared when the encoder hands each block downstream.
`timescale 1ns/1ps
module tb_pcs_tx_encoder;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [31:0] in_xgmii_data;
    logic [3:0]  in_xgmii_ctl;
    logic        out_xgmii_pcs_ready;
    logic [65:0] out_block;
    logic        out_block_valid;
    logic        in_block_ready;
    logic        enc_error;
    logic [31:0] stat_error_blocks;

    pcs_tx_encoder #(
        .XGMII_DATA_WIDTH (32),
        .XGMII_DATA_BYTES (4)
    ) dut (
        .tx_clk              (tx_clk),
        .tx_rst              (tx_rst),
        .in_xgmii_data       (in_xgmii_data),
        .in_xgmii_ctl        (in_xgmii_ctl),
        .out_xgmii_pcs_ready (out_xgmii_pcs_ready),
        .out_block           (out_block),
        .out_block_valid     (out_block_valid),
        .in_block_ready      (in_block_ready),
        .enc_error           (enc_error),
        .stat_error_blocks   (stat_error_blocks)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [65:0] blk;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned exp_stat = 0;
    logic        prev_valid = 1'b0;
    logic [65:0] held_block = '0;
    logic [65:0] err_blk;
    exp_t        head;

    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b10};
    localparam logic [65:0] T0_BLK   = {56'h0, 8'h87, 2'b10};

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [65:0] build_err_block();
        logic [63:0] p;
        p      = '0;
        p[7:0] = 8'h1E;
        for (int i = 0; i < 8; i++) begin
            p[8 + 7*i +: 7] = 7'h1E;
        end
        return {p, 2'b10};
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] c);
        int unsigned waited;
        logic        done;
        in_xgmii_data = d;
        in_xgmii_ctl  = c;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge tx_clk);
            if (out_xgmii_pcs_ready) begin
                @(posedge tx_clk);
                #1;
                done = 1'b1;
            end else if (waited >= 50) begin
                check("accept_timeout", 66'(out_xgmii_pcs_ready), 66'(1'b1));
                done = 1'b1;
            end else begin
                waited++;
            end
        end
    endtask

    task automatic send_pair(input logic [31:0] lo, input logic [3:0] loc,
                             input logic [31:0] hi, input logic [3:0] hic,
                             input logic [65:0] blk, input logic err);
        exp_t e;
        drive_beat(lo, loc);
        drive_beat(hi, hic);
        e.blk = blk;
        e.err = err;
        exp_q.push_back(e);
    endtask

    always @(negedge tx_clk) begin
        if (!tx_rst) begin
            if (out_block_valid && !prev_valid) begin
                held_block = out_block;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 66'(exp_q.size()), 66'(1));
                end else begin
                    head = exp_q[0];
                    check("enc_error", 66'(enc_error), 66'(head.err));
                    if (head.err) exp_stat++;
                    check("stat_error_blocks", 66'(stat_error_blocks), 66'(exp_stat));
                end
            end else begin
                check("enc_error_quiet", 66'(enc_error), 66'(1'b0));
            end
            if (out_block_valid && !in_block_ready) begin
                check("bp_pcs_ready", 66'(out_xgmii_pcs_ready), 66'(1'b0));
                check("bp_block_hold", out_block, held_block);
            end
            if (out_block_valid && in_block_ready && exp_q.size() != 0) begin
                head = exp_q.pop_front();
                check("out_block", out_block, head.blk);
            end
        end
        prev_valid = out_block_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        err_blk        = build_err_block();
        tx_rst         = 1'b1;
        in_block_ready = 1'b1;
        in_xgmii_data  = 32'h07070707;
        in_xgmii_ctl   = 4'hF;
        repeat (2) @(posedge tx_clk);
        #1;
        check("rst_block", out_block, 66'h0);
        check("rst_valid", 66'(out_block_valid), 66'(1'b0));
        check("rst_enc_error", 66'(enc_error), 66'(1'b0));
        check("rst_stat", 66'(stat_error_blocks), 66'(0));
        check("rst_pcs_ready", 66'(out_xgmii_pcs_ready), 66'(1'b1));
        tx_rst = 1'b0;

        // idle, then a full frame with T in lane 0
        send_pair(32'h07070707, 4'hF, 32'h07070707, 4'hF, IDLE_BLK, 1'b0);
        send_pair(32'h555555FB, 4'h1, 32'hD5555555, 4'h0,
                  {64'hD5555555_55555578, 2'b10}, 1'b0);
        send_pair(32'h04030201, 4'h0, 32'h08070605, 4'h0,
                  {64'h08070605_04030201, 2'b01}, 1'b0);
        send_pair(32'h070707FD, 4'hF, 32'h07070707, 4'hF, T0_BLK, 1'b0);

        // frame ending with T in lane 5
        send_pair(32'hC3B2A1FB, 4'h1, 32'hF7E6D5C4, 4'h0,
                  {64'hF7E6D5C4_C3B2A178, 2'b10}, 1'b0);
        send_pair(32'h44332211, 4'h0, 32'h0707FDDD, 4'hE,
                  {64'h0000DD44_332211D2, 2'b10}, 1'b0);

        // data while idle is a sequence violation; idle recovers
        send_pair(32'hA3A2A1A0, 4'h0, 32'hB3B2B1B0, 4'h0, err_blk, 1'b1);
        send_pair(32'h07070707, 4'hF, 32'h07070707, 4'hF, IDLE_BLK, 1'b0);

        // start in lane 4, terminate in lane 7
        send_pair(32'h07070707, 4'hF, 32'hA3A2A1FB, 4'h1,
                  {64'hA3A2A100_00000033, 2'b10}, 1'b0);
        send_pair(32'h14131211, 4'h0, 32'hFD171615, 4'h8,
                  {64'h17161514_131211FF, 2'b10}, 1'b0);

        // malformed lanes, then data directly out of the error state
        send_pair(32'h07070707, 4'hF, 32'h07075507, 4'hD, err_blk, 1'b1);
        send_pair(32'h33221100, 4'h0, 32'h77665544, 4'h0,
                  {64'h77665544_33221100, 2'b01}, 1'b0);
        send_pair(32'h070707FD, 4'hF, 32'h07070707, 4'hF, T0_BLK, 1'b0);

        // downstream stall for 5 cycles with a block pending
        fork
            begin
                send_pair(32'h07070707, 4'hF, 32'h07070707, 4'hF, IDLE_BLK, 1'b0);
                send_pair(32'h07FE0707, 4'hF, 32'hFE070707, 4'hF,
                          {64'h3C000000_0780001E, 2'b10}, 1'b0);
                send_pair(32'h07070707, 4'hF, 32'h07070707, 4'hF, IDLE_BLK, 1'b0);
            end
            begin
                repeat (2) @(posedge tx_clk);
                #1 in_block_ready = 1'b0;
                repeat (5) @(posedge tx_clk);
                #1 in_block_ready = 1'b1;
            end
        join

        // reset with only a low beat captured
        drive_beat(32'h07070707, 4'hF);
        tx_rst        = 1'b1;
        in_xgmii_data = 32'hDEADBEEF;
        in_xgmii_ctl  = 4'h0;
        @(posedge tx_clk);
        #1;
        check("rst2_block", out_block, 66'h0);
        check("rst2_valid", 66'(out_block_valid), 66'(1'b0));
        check("rst2_enc_error", 66'(enc_error), 66'(1'b0));
        check("rst2_stat", 66'(stat_error_blocks), 66'(0));
        exp_stat = 0;
        tx_rst   = 1'b0;
        send_pair(32'h9A8B7CFB, 4'h1, 32'h0F1E2D3C, 4'h0,
                  {64'h0F1E2D3C_9A8B7C78, 2'b10}, 1'b0);
        send_pair(32'h070707FD, 4'hF, 32'h07070707, 4'hF, T0_BLK, 1'b0);

        @(negedge tx_clk);
        #1;
        check("sb_empty", 66'(exp_q.size()), 66'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcs_tx_encoder.md
PCS_TX_ENCODER -- requirements
Module: pcs_tx_encoder

Interface
REQ-001 SHALL have parameter XGMII_DATA_WIDTH, default 32, XGMII beat width (only 32 supported).
REQ-002 SHALL have parameter XGMII_DATA_BYTES, default XGMII_DATA_WIDTH/8, lanes per beat.
REQ-003 SHALL have port tx_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port tx_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_xgmii_data, input, 32, XGMII TX data from MAC; lane n = bits [8n+7:8n].
REQ-006 SHALL have port in_xgmii_ctl, input, 4, per-lane control flag (1 = control character).
REQ-007 SHALL have port out_xgmii_pcs_ready, output, 1, beat accepted in any cycle this is high.
REQ-008 SHALL have port out_block, output, 66, encoded block: [1:0] sync header, [65:2] payload, [9:2] block type.
REQ-009 SHALL have port out_block_valid, output, 1, out_block is valid.
REQ-010 SHALL have port in_block_ready, input, 1, downstream (scrambler/gearbox) accepts block.
REQ-011 SHALL have port enc_error, output, 1, one-cycle pulse when an error block is emitted.
REQ-012 SHALL have port stat_error_blocks, output, 32, saturating count of emitted error blocks.

Function
REQ-013 SHALL drive out_xgmii_pcs_ready = !out_block_valid || in_block_ready (combinational).
REQ-014 SHALL pair accepted beats: first beat after reset = lanes 0-3 (low phase), next = lanes 4-7 (high phase), alternating; phase toggles only on acceptance.
REQ-015 SHALL register the encoded block on high-phase acceptance; out_block_valid rises the next cycle (latency 1 cycle after second beat).
REQ-016 SHALL hold out_block and out_block_valid stable while out_block_valid && !in_block_ready; valid clears on handshake unless a new block loads same cycle.
REQ-017 SHALL classify 8 lanes: D = no ctl lanes; C = all ctl, each /I/ 0x07 or /E/ 0xFE; S = /S/ 0xFB in lane 0 with data lanes 1-7, or lane 4 with /I/ lanes 0-3 and data lanes 5-7; T = /T/ 0xFD in lane k (0-7), data lanes <k, /I/ lanes >k; anything else = E.
REQ-018 SHALL encode D with sync 2'b01, payload = 8 data bytes lane 0 first; all others sync 2'b10.
REQ-019 SHALL encode C as type 0x1E with eight 7-bit codes (/I/=0x00, /E/=0x1E); S lane0 as 0x78 + lanes 1-7 data; S lane4 as 0x33 + four 0x00 codes, 4-bit zero, lanes 5-7 data.
REQ-020 SHALL encode T by k as types 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF, data lanes <k packed after type, zero fill, 7-bit 0x00 for idle lanes.
REQ-021 SHALL encode E (and sequence violations) as type 0x1E with eight 0x1E codes, assert enc_error 1 cycle with load, increment stat_error_blocks saturating at 0xFFFFFFFF.
REQ-022 SHALL run sequence FSM INIT, C, D, E updated per loaded block: INIT/C: C->C, S->D, else E; D: D->D, T->C, else E; E: C->C, D->D, T->C, S->D, else E.
REQ-023 SHALL treat a class legal by REQ-017 but illegal by REQ-022 as E (error block emitted, FSM to E).

Reset
REQ-024 SHALL, on tx_rst high at clock edge, set out_block_valid=0, out_block=0, enc_error=0, stat_error_blocks=0, phase=low, FSM=INIT, discard any captured low beat.
REQ-025 SHALL drive out_xgmii_pcs_ready high during reset-cycle evaluation per REQ-013 (valid is 0 after reset).
REQ-026 SHALL take reset priority over simultaneous beat acceptance or block handshake.

Structure
REQ-027 SHALL place XGMII characters (0x07,0xFB,0xFD,0xFE), 7-bit codes, block-type constants, sync-header values, FSM state encodings in shared package pcs_pkg.
REQ-028 SHALL factor the combinational 8-lane classifier/encoder as sub-module pcs_block_encode; FSM, phase, output register and counter stay in pcs_tx_encoder.

Verification
REQ-029 SHALL cover idle: beats 0x07070707/ctl 0xF twice -> block sync 2'b10, type 0x1E, payload codes zero, 1 cycle after second beat.
REQ-030 SHALL cover frame: {FB,55,55,55}/0x1, {55,55,55,D5}/0x0, then 8 data bytes, then {FD,07,07,07}/0xF x2 -> types 0x78, 0x01-sync data, 0x87; enc_error never.
REQ-031 SHALL cover T at lane 5: low beat data/0x0, high {DD,FD,07,07}/0xE -> type 0xD2, five data bytes, FSM to C.
REQ-032 SHALL cover violation: data block while FSM=C -> type 0x1E with eight 0x1E codes, enc_error pulse, stat_error_blocks=1.
REQ-033 SHALL cover back-pressure: in_block_ready=0 for 5 cycles with block pending -> out_block stable, out_xgmii_pcs_ready=0, no beat lost after release.
REQ-034 SHALL cover reset after low beat only: tx_rst 1 cycle -> outputs zero, next accepted beat treated as lanes 0-3.
